fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch and issue sequencer that drives the 4-bit opcode consumed by the control unit. Fetches 16-bit instructions from instruction memory over a req/ready handshake, holds them in an instruction register, issues opcode and 8-bit operand for one decode cycle, then waits for execute completion. Updates the program counter sequentially or from a jump/branch target.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `INSTR_W`, default 16: instruction width; opcode = `[INSTR_W-1:INSTR_W-4]`, operand = `[7:0]`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request, high throughout FETCH.
- `imem_addr`  out  8  fetch address (current PC).
- `imem_ready`  in  1  instruction memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  INSTR_W  fetched instruction.
- `opcode`  out  4  opcode field of the instruction register, to the control unit.
- `operand`  out  8  operand field of the instruction register.
- `issue_valid`  out  1  one-cycle pulse; `opcode`/`operand` are newly valid.
- `exec_done`  in  1  datapath finished the issued instruction.
- `jump`  in  1  redirect to `target_addr`, sampled with `exec_done`.
- `branch_taken`  in  1  taken branch, sampled with `exec_done`.
- `target_addr`  in  8  redirect target.
- `pc`  out  8  current program counter.
- `halted`  out  1  sequencer in HALT (only with `FETCH_HALT_EN`).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT (HALT only with `FETCH_HALT_EN`).
- IDLE: reset state; unconditionally -> FETCH on next edge.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, held stable until handshake. Edge with `imem_ready`=1: IR <= `imem_rdata`, -> DECODE. Otherwise stay.
- DECODE: `issue_valid`=1 for exactly this cycle; -> EXEC on next edge.
- EXEC: wait. Edge with `exec_done`=1: if `jump` or `branch_taken`, `pc` <= `target_addr`; else `pc` <= `pc`+1 modulo 256 (8'hFF -> 8'h00). -> FETCH.
- `jump` and `branch_taken` both high: single redirect to `target_addr`.
- `opcode`/`operand` driven continuously from IR; change only on FETCH completion.
- `imem_ready` outside FETCH and `exec_done`/`jump`/`branch_taken` outside EXEC are ignored.
- Reset values: state IDLE, `pc`=`RESET_PC`, IR=0 (so `opcode`=0, `operand`=0), `imem_req`=0, `issue_valid`=0, `halted`=0. `imem_addr`=`RESET_PC`.
- Reset asserted mid-fetch or mid-execute: immediate return to reset values; no IR or PC update completes.

## Timing
- `imem_req`, `issue_valid`, `halted` are decoded from registered state only (no combinational path from inputs).
- Zero-wait memory: FETCH 1 cycle, DECODE 1, EXEC ≥1; minimum 3 cycles per instruction.
- First `imem_req` asserted 1 cycle after reset deassertion (IDLE cycle).
- Redirect visible on `imem_addr` in the first FETCH cycle after the `exec_done` edge.
- `imem_ready` may be high in the first FETCH cycle; accepted immediately.

## Configuration
- `FETCH_HALT_EN` defined: opcode 4'b1111 at DECODE still pulses `issue_valid`, then enters HALT instead of EXEC; HALT holds `pc`, `imem_req`=0, `halted`=1 until reset.
- Not defined: 4'b1111 issued and executed like any opcode; HALT state absent, `halted` tied 0.

## Test plan
- Reset with `RESET_PC`=8'h10, zero-wait memory returning 16'h2005 -> `imem_addr`=8'h10, one `issue_valid` with `opcode`=4'h2, `operand`=8'h05; after `exec_done`, next fetch at 8'h11.
- `imem_ready` delayed 4 cycles -> `imem_req` and `imem_addr` stable for 5 cycles, no `issue_valid` until capture.
- `exec_done`+`jump` with `target_addr`=8'h40 -> next `imem_addr`=8'h40; `jump`+`branch_taken` together with 8'h22 -> 8'h22.
- PC at 8'hFF, sequential `exec_done` -> next `imem_addr`=8'h00.
- `rst` asserted during EXEC and during stalled FETCH -> outputs return to reset values immediately; restart at `RESET_PC`.
- With `FETCH_HALT_EN`, fetch 16'hF000 -> one `issue_valid`, `halted`=1, `imem_req`=0 for 20 cycles; without macro, sequencer proceeds to EXEC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch / issue sequencer feeding the control unit.
// Fetches an instruction over a req/ready handshake, latches it in the
// instruction register, pulses issue_valid for one decode cycle, then waits
// for exec_done and advances the PC sequentially or to a redirect target.
// Optional feature macro: FETCH_HALT_EN (opcode 4'b1111 enters a HALT state).
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [7:0]         imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [7:0]         operand,
  output logic               issue_valid,
  input  logic               exec_done,
  input  logic               jump,
  input  logic               branch_taken,
  input  logic [7:0]         target_addr,
  output logic [7:0]         pc,
  output logic               halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC
`ifdef FETCH_HALT_EN
    , HALT
`endif
  } state_t;

  state_t             state_reg;
  logic [7:0]         pc_reg;
  logic [INSTR_W-1:0] ir_reg;
  logic               req_reg;
  logic               issue_reg;
`ifdef FETCH_HALT_EN
  logic               halted_reg;
`endif

  // Sequencer FSM: state, PC, instruction register and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      ir_reg     <= '0;
      req_reg    <= 1'b0;
      issue_reg  <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
          req_reg   <= 1'b1;
        end
        FETCH: begin
          // Address and request stay put until memory answers.
          if (imem_ready) begin
            ir_reg    <= imem_rdata;
            state_reg <= DECODE;
            req_reg   <= 1'b0;
            issue_reg <= 1'b1;
          end
        end
        DECODE: begin
          issue_reg <= 1'b0;
`ifdef FETCH_HALT_EN
          if (ir_reg[INSTR_W-1 -: 4] == 4'hF) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else begin
            state_reg <= EXEC;
          end
`else
          state_reg <= EXEC;
`endif
        end
        EXEC: begin
          // jump and branch_taken together still mean a single redirect.
          if (exec_done) begin
            pc_reg    <= (jump || branch_taken) ? target_addr : pc_reg + 8'd1;
            state_reg <= FETCH;
            req_reg   <= 1'b1;
          end
        end
`ifdef FETCH_HALT_EN
        HALT: begin
          state_reg <= HALT;
        end
`endif
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          issue_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign issue_valid = issue_reg;
  assign opcode      = ir_reg[INSTR_W-1 -: 4];
  assign operand     = ir_reg[7:0];
`ifdef FETCH_HALT_EN
  assign halted      = halted_reg;
`else
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer (RESET_PC = 8'h10).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        issue_valid;
  logic        exec_done;
  logic        jump;
  logic        branch_taken;
  logic [7:0]  target_addr;
  logic [7:0]  pc;
  logic        halted;

  int vectors;
  int miscompares;

  fetch_sequencer #(.RESET_PC(8'h10), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .opcode(opcode), .operand(operand), .issue_valid(issue_valid),
    .exec_done(exec_done), .jump(jump), .branch_taken(branch_taken),
    .target_addr(target_addr), .pc(pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an instruction for one edge; returns at the falling edge in DECODE.
  task automatic do_fetch(input logic [15:0] instr);
    imem_ready = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  // Complete execution; returns at the falling edge in the next FETCH.
  task automatic do_exec(input logic j, input logic b, input logic [7:0] t);
    exec_done    = 1'b1;
    jump         = j;
    branch_taken = b;
    target_addr  = t;
    @(negedge clk);
    exec_done    = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    target_addr  = 8'h00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({pc, imem_addr, opcode, operand, imem_req, issue_valid, halted} !==
        {8'h10, 8'h10, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: pc=%h addr=%h op=%h opd=%h req=%b iv=%b h=%b required 10 10 0 00 0 0 0",
               pc, imem_addr, opcode, operand, imem_req, issue_valid, halted);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h10}) begin
      miscompares++;
      $display("FAIL first_req: req=%b addr=%h required 1 10", imem_req, imem_addr);
    end
    $display("test_reset done: pc=%h req=%b", pc, imem_req);
  endtask

  task automatic test_basic_fetch();
    do_fetch(16'h2005);
    vectors++;
    if ({issue_valid, opcode, operand, imem_req} !== {1'b1, 4'h2, 8'h05, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_issue: iv=%b op=%h opd=%h req=%b required 1 2 05 0",
               issue_valid, opcode, operand, imem_req);
    end
    @(negedge clk);
    vectors++;
    if ({issue_valid, imem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_exec: iv=%b req=%b required 0 0", issue_valid, imem_req);
    end
    do_exec(1'b0, 1'b0, 8'h00);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h11}) begin
      miscompares++;
      $display("FAIL basic_next_pc: req=%b addr=%h required 1 11", imem_req, imem_addr);
    end
    $display("test_basic_fetch done: op=%h opd=%h next addr=%h", opcode, operand, imem_addr);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({imem_req, imem_addr, issue_valid} !== {1'b1, 8'h11, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: req=%b addr=%h iv=%b required 1 11 0",
                 i, imem_req, imem_addr, issue_valid);
      end
      @(negedge clk);
    end
    vectors++;
    if ({imem_req, imem_addr, issue_valid} !== {1'b1, 8'h11, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_cycle4: req=%b addr=%h iv=%b required 1 11 0",
               imem_req, imem_addr, issue_valid);
    end
    do_fetch(16'h3A7C);
    vectors++;
    if ({issue_valid, opcode, operand} !== {1'b1, 4'h3, 8'h7C}) begin
      miscompares++;
      $display("FAIL stall_capture: iv=%b op=%h opd=%h required 1 3 7c", issue_valid, opcode, operand);
    end
    // exec_done/jump during DECODE and imem_ready during EXEC must be ignored.
    exec_done   = 1'b1;
    jump        = 1'b1;
    target_addr = 8'h99;
    @(negedge clk);
    exec_done   = 1'b0;
    jump        = 1'b0;
    imem_ready  = 1'b1;
    imem_rdata  = 16'hBEEF;
    @(negedge clk);
    imem_ready  = 1'b0;
    vectors++;
    if ({imem_req, pc, opcode, operand} !== {1'b0, 8'h11, 4'h3, 8'h7C}) begin
      miscompares++;
      $display("FAIL ignore_outside: req=%b pc=%h op=%h opd=%h required 0 11 3 7c",
               imem_req, pc, opcode, operand);
    end
    $display("test_stall done: op=%h opd=%h pc=%h", opcode, operand, pc);
  endtask

  task automatic test_redirect();
    do_exec(1'b1, 1'b0, 8'h40);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h40}) begin
      miscompares++;
      $display("FAIL jump_target: req=%b addr=%h required 1 40", imem_req, imem_addr);
    end
    do_fetch(16'h1111);
    @(negedge clk);
    do_exec(1'b1, 1'b1, 8'h22);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h22}) begin
      miscompares++;
      $display("FAIL jump_and_branch: req=%b addr=%h required 1 22", imem_req, imem_addr);
    end
    do_fetch(16'h4444);
    @(negedge clk);
    do_exec(1'b0, 1'b1, 8'hFF);
    vectors++;
    if (imem_addr !== 8'hFF) begin
      miscompares++;
      $display("FAIL branch_target: addr=%h required ff", imem_addr);
    end
    $display("test_redirect done: addr=%h", imem_addr);
  endtask

  task automatic test_wrap();
    do_fetch(16'h5501);
    @(negedge clk);
    do_exec(1'b0, 1'b0, 8'h00);
    vectors++;
    if ({imem_req, imem_addr, pc} !== {1'b1, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL pc_wrap: req=%b addr=%h pc=%h required 1 00 00", imem_req, imem_addr, pc);
    end
    $display("test_wrap done: addr=%h", imem_addr);
  endtask

  task automatic test_reset_mid();
    do_fetch(16'h1234);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({pc, opcode, operand, imem_req, issue_valid} !== {8'h10, 4'h0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_in_exec: pc=%h op=%h opd=%h req=%b iv=%b required 10 0 00 0 0",
               pc, opcode, operand, imem_req, issue_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h10}) begin
      miscompares++;
      $display("FAIL restart_after_exec_reset: req=%b addr=%h required 1 10", imem_req, imem_addr);
    end
    @(negedge clk);
    // Reset lands together with the handshake; the capture must not happen.
    imem_ready = 1'b1;
    imem_rdata = 16'hABCD;
    rst = 1'b1;
    #1;
    vectors++;
    if ({imem_req, pc} !== {1'b0, 8'h10}) begin
      miscompares++;
      $display("FAIL reset_in_fetch: req=%b pc=%h required 0 10", imem_req, pc);
    end
    @(negedge clk);
    vectors++;
    if ({opcode, operand, issue_valid} !== {4'h0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL no_capture_in_reset: op=%h opd=%h iv=%b required 0 00 0", opcode, operand, issue_valid);
    end
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr, opcode} !== {1'b1, 8'h10, 4'h0}) begin
      miscompares++;
      $display("FAIL restart_after_fetch_reset: req=%b addr=%h op=%h required 1 10 0",
               imem_req, imem_addr, opcode);
    end
    $display("test_reset_mid done: addr=%h", imem_addr);
  endtask

  task automatic test_opcode_f();
    do_fetch(16'hF000);
    vectors++;
    if ({issue_valid, opcode} !== {1'b1, 4'hF}) begin
      miscompares++;
      $display("FAIL opf_issue: iv=%b op=%h required 1 f", issue_valid, opcode);
    end
    @(negedge clk);
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 20; i++) begin
      exec_done  = 1'b1;
      imem_ready = 1'b1;
      vectors++;
      if ({halted, imem_req, issue_valid, pc} !== {1'b1, 1'b0, 1'b0, 8'h10}) begin
        miscompares++;
        $display("FAIL halt_hold%0d: h=%b req=%b iv=%b pc=%h required 1 0 0 10",
                 i, halted, imem_req, issue_valid, pc);
      end
      @(negedge clk);
    end
    exec_done  = 1'b0;
    imem_ready = 1'b0;
    $display("test_opcode_f done: halted=%b", halted);
`else
    vectors++;
    if ({halted, imem_req, issue_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL opf_exec: h=%b req=%b iv=%b required 0 0 0", halted, imem_req, issue_valid);
    end
    do_exec(1'b0, 1'b0, 8'h00);
    vectors++;
    if ({imem_req, imem_addr, halted} !== {1'b1, 8'h11, 1'b0}) begin
      miscompares++;
      $display("FAIL opf_next: req=%b addr=%h h=%b required 1 11 0", imem_req, imem_addr, halted);
    end
    $display("test_opcode_f done: next addr=%h", imem_addr);
`endif
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    imem_ready   = 1'b0;
    imem_rdata   = 16'h0000;
    exec_done    = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    target_addr  = 8'h00;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_opcode_f();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
